aemb_xwbarb: RTL
================

Name: aemb_xwbarb

Overview:
- Two-master to one-slave Wishbone arbiter for the AEMB core.
- Shares one external memory port between the data bus (master 0, from the dwb interface) and the instruction bus (master 1, from the fetch unit).
- Uses a registered grant FSM with round-robin fairness and lossless pass-through of single or locked (held-cyc) transfers.
- Sits between the core's bus interfaces and the system bus.

Parameters:
AW, 32, address width; address buses are [AW-1:2] (word addressed).
TMO, 255, watchdog limit in cycles, only with the optional feature; 8-bit counter, legal range 1..255.

Ports:
gclk  in  1  system clock, all state on rising edge.
grst  in  1  synchronous active-high reset.
mN_adr_i  in  AW-2  master N address, N=0 (data), N=1 (instruction).
mN_dat_i  in  32  master N write data.
mN_sel_i  in  4  master N byte select.
mN_stb_i  in  1  master N strobe.
mN_cyc_i  in  1  master N cycle; held high to lock the bus.
mN_wre_i  in  1  master N write enable.
mN_tag_i  in  1  master N tag.
mN_dat_o  out  32  read data to master N.
mN_ack_o  out  1  acknowledge to master N.
s_adr_o  out  AW-2  slave address.
s_dat_o  out  32  slave write data.
s_sel_o  out  4  slave byte select.
s_stb_o  out  1  slave strobe.
s_cyc_o  out  1  slave cycle.
s_wre_o  out  1  slave write enable.
s_tag_o  out  1  slave tag.
s_dat_i  in  32  slave read data.
s_ack_i  in  1  slave acknowledge.
gnt_o  out  2  one-hot current grant; 00 when idle.
tmo_o  out  1  sticky watchdog flag.

Behaviour:
- Request: reqN = mN_cyc_i & mN_stb_i. A strobe without cyc is ignored.
- FSM states: IDLE, BUS0, BUS1. State, gnt_o and the round-robin pointer lst are registered.
- IDLE:
  - Only reqN -> BUSN.
  - Both requesting -> BUS(~lst).
  - No request -> stay IDLE.
- BUSN:
  - Stay while mN_cyc_i=1.
  - mN_cyc_i=0 and other master requesting -> BUS(other) directly, no idle bubble.
  - Otherwise -> IDLE.
  - lst <= N on entry to BUSN.
- Latency: request sampled in IDLE -> s_cyc_o/s_stb_o high on the next cycle.
- Slave-side outputs are a combinational mux of the granted master's signals.
  - In IDLE all slave-side outputs are 0.
  - In BUSN, s_stb_o = mN_stb_i and s_cyc_o = mN_cyc_i.
- mN_ack_o = s_ack_i & (state==BUSN). A stray s_ack_i in IDLE is dropped.
- mN_dat_o = s_dat_i to both masters; only the acked master samples it.
- Locked transfers: master N holding cyc across multiple stb pulses keeps the grant, even with the other master requesting.
- Simultaneous cyc drop and other-master request in the same cycle: switch takes effect the next cycle. The dropping master's final ack, if any, is delivered in the current cycle.
- Reset values: state=IDLE, gnt_o=00, lst=1 (master 0 wins the first contention), tmo_o=0, all slave-side outputs 0, mN_ack_o=0.
- grst mid-transfer:
  - Grant is released immediately and the slave sees cyc/stb drop the next cycle.
  - Any in-flight ack after reset is not forwarded.

Optional Feature:
- Macro: AEMB_XWBARB_TIMEOUT_EN.
- Enabled:
  - An 8-bit counter clears on state change or s_ack_i, and increments each cycle in BUSN with s_stb_o=1.
  - When it reaches TMO, the arbiter issues a one-cycle mN_ack_o to the granted master with mN_dat_o=32'h0, forces s_cyc_o/s_stb_o low that cycle, goes to IDLE and sets tmo_o.
  - tmo_o clears only on grst.
- Disabled: no counter; tmo_o is tied 0.

Decomposition:
- Shared package aemb_xwbarb_pkg holds:
  - State encodings IDLE=2'd0, BUS0=2'd1, BUS1=2'd2.
  - Grant encodings GNT_NONE=2'b00, GNT_M0=2'b01, GNT_M1=2'b10.
  - Counter width localparam TMW=8.
- One sub-module: aemb_xwbarb_tmo (watchdog counter), instantiated only under the macro.

Test Plan:
1. Master 0 single read, adr=30'h100, slave acks in cycle 2 with dat=32'hDEADBEEF -> s_cyc_o one cycle after request, m0_ack_o=1 with m0_dat_o=32'hDEADBEEF, m1_ack_o=0, return to IDLE, gnt_o=00.
2. Both masters request on the same cycle after reset -> BUS0 first; when m0 drops cyc, BUS1 the very next cycle; repeat contention -> BUS0 again (alternation over 4 rounds).
3. Master 1 locks cyc for 3 strobes (adr 0x10, 0x11, 0x12) while master 0 requests -> all 3 forwarded to master 1, master 0 granted only after m1_cyc_i falls.
4. grst asserted in BUS0 with strobe pending -> next cycle gnt_o=00, s_cyc_o=0; a late s_ack_i=1 -> m0_ack_o stays 0.
5. With AEMB_XWBARB_TIMEOUT_EN, TMO=4, slave never acks -> m0_ack_o pulses after the 4th strobed cycle with m0_dat_o=0, tmo_o=1 and stays 1 until grst.

Source files
------------

// File: rtl/aemb_xwbarb_pkg.sv
// Shared encodings for the AEMB two-master Wishbone arbiter.
package aemb_xwbarb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS0 = 2'd1,
        BUS1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam int TMW = 8;

    function automatic logic [1:0] gnt_of(arb_state_e s);
        case (s)
            BUS0:    return GNT_M0;
            BUS1:    return GNT_M1;
            default: return GNT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/aemb_xwbarb_if.sv
// Wishbone link between one master and one slave; dat_w flows to the slave, dat_r back.
interface aemb_xwbarb_if #(parameter int AW = 32);

    logic [AW-1:2] adr;
    logic [31:0]   dat_w;
    logic [3:0]    sel;
    logic          stb;
    logic          cyc;
    logic          wre;
    logic          tag;
    logic [31:0]   dat_r;
    logic          ack;

    modport master (output adr, dat_w, sel, stb, cyc, wre, tag, input dat_r, ack);
    modport slave  (input adr, dat_w, sel, stb, cyc, wre, tag, output dat_r, ack);

endinterface

// File: rtl/aemb_xwbarb_tmo.sv
// Bus watchdog: counts strobed cycles without an ack and flags when the limit is reached.
module aemb_xwbarb_tmo
    import aemb_xwbarb_pkg::*;
#(
    parameter int TMO = 255
) (
    input  logic gclk,
    input  logic grst,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    logic [TMW-1:0] cnt;

    always_ff @(posedge gclk) begin
        if (grst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Forcing stb low on a hit stops the count, so it never wraps past TMO.
    assign hit = (cnt == TMW'(TMO));

endmodule

// File: rtl/aemb_xwbarb.sv
// Two-master (0 = data, 1 = instruction) to one-slave Wishbone arbiter with round-robin grant.
// Optional bus watchdog enabled by defining AEMB_XWBARB_TIMEOUT_EN.
module aemb_xwbarb
    import aemb_xwbarb_pkg::*;
#(
    parameter int AW  = 32,
    parameter int TMO = 255
) (
    input  logic             gclk,
    input  logic             grst,
    aemb_xwbarb_if.slave     m0,
    aemb_xwbarb_if.slave     m1,
    aemb_xwbarb_if.master    s,
    output logic [1:0]       gnt_o,
    output logic             tmo_o
);

    // state | meaning
    // IDLE  | no grant, slave side driven to zero
    // BUS0  | data master owns the slave until it drops cyc
    // BUS1  | instruction master owns the slave until it drops cyc

    if (TMO < 1 || TMO > 255) begin : g_tmo_range
        $error("aemb_xwbarb: TMO must be within 1..255");
    end

    arb_state_e    state;
    arb_state_e    state_nxt;
    logic          lst;
    logic          req0;
    logic          req1;
    logic          tmo_hit;

    logic [AW-1:2] adr_mux;
    logic [31:0]   dat_mux;
    logic [3:0]    sel_mux;
    logic          stb_mux;
    logic          cyc_mux;
    logic          wre_mux;
    logic          tag_mux;

    assign req0 = m0.cyc & m0.stb;
    assign req1 = m1.cyc & m1.stb;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0 && req1)  state_nxt = lst ? BUS0 : BUS1;
                else if (req0)     state_nxt = BUS0;
                else if (req1)     state_nxt = BUS1;
            end
            BUS0: if (!m0.cyc)     state_nxt = req1 ? BUS1 : IDLE;
            BUS1: if (!m1.cyc)     state_nxt = req0 ? BUS0 : IDLE;
            default:               state_nxt = IDLE;
        endcase
        if (tmo_hit) state_nxt = IDLE;
    end

    always_ff @(posedge gclk) begin
        if (grst) begin
            state <= IDLE;
            gnt_o <= GNT_NONE;
            lst   <= 1'b1;
        end else begin
            state <= state_nxt;
            gnt_o <= gnt_of(state_nxt);
            if (state_nxt == BUS0 && state != BUS0)      lst <= 1'b0;
            else if (state_nxt == BUS1 && state != BUS1) lst <= 1'b1;
        end
    end

    always_comb begin
        adr_mux = '0;
        dat_mux = '0;
        sel_mux = '0;
        stb_mux = 1'b0;
        cyc_mux = 1'b0;
        wre_mux = 1'b0;
        tag_mux = 1'b0;
        case (state)
            BUS0: begin
                adr_mux = m0.adr;
                dat_mux = m0.dat_w;
                sel_mux = m0.sel;
                stb_mux = m0.stb;
                cyc_mux = m0.cyc;
                wre_mux = m0.wre;
                tag_mux = m0.tag;
            end
            BUS1: begin
                adr_mux = m1.adr;
                dat_mux = m1.dat_w;
                sel_mux = m1.sel;
                stb_mux = m1.stb;
                cyc_mux = m1.cyc;
                wre_mux = m1.wre;
                tag_mux = m1.tag;
            end
            default: ;
        endcase
        // A watchdog abort withdraws the cycle from the slave in the same clock.
        if (tmo_hit) begin
            stb_mux = 1'b0;
            cyc_mux = 1'b0;
        end
    end

    assign s.adr   = adr_mux;
    assign s.dat_w = dat_mux;
    assign s.sel   = sel_mux;
    assign s.stb   = stb_mux;
    assign s.cyc   = cyc_mux;
    assign s.wre   = wre_mux;
    assign s.tag   = tag_mux;

    assign m0.ack   = (state == BUS0) & (s.ack | tmo_hit);
    assign m1.ack   = (state == BUS1) & (s.ack | tmo_hit);
    assign m0.dat_r = tmo_hit ? 32'h0 : s.dat_r;
    assign m1.dat_r = tmo_hit ? 32'h0 : s.dat_r;

`ifdef AEMB_XWBARB_TIMEOUT_EN
    logic tmo_clr;
    logic tmo_inc;

    assign tmo_clr = (state_nxt != state) | s.ack;
    assign tmo_inc = stb_mux;

    aemb_xwbarb_tmo #(.TMO(TMO)) u_tmo (
        .gclk (gclk),
        .grst (grst),
        .clr  (tmo_clr),
        .inc  (tmo_inc),
        .hit  (tmo_hit)
    );

    always_ff @(posedge gclk) begin
        if (grst)         tmo_o <= 1'b0;
        else if (tmo_hit) tmo_o <= 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
    assign tmo_o   = 1'b0;
`endif

endmodule
